// File: rtl/smc_pwm_meter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | smc_pwm_meter_if                                                           |
// | Q-bus register access plus the controller PWM lines seen by the meter.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface smc_pwm_meter_if;
  logic        QWRITE;
  logic        QSEL;
  logic [6:0]  QADDR;
  logic [15:0] QDATAIN;
  logic [15:0] QDATAOUT;
  logic [11:0] MNM;
  logic [11:0] MNP;
  logic        IRQ;

  modport master (
    output QWRITE, QSEL, QADDR, QDATAIN, MNM, MNP,
    input  QDATAOUT, IRQ
  );

  modport slave (
    input  QWRITE, QSEL, QADDR, QDATAIN, MNM, MNP,
    output QDATAOUT, IRQ
  );
endinterface
`default_nettype wire

// File: rtl/smc_pwm_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | smc_pwm_meter                                                              |
// | Period / high-time meter for one selected MNM/MNP line, Q-bus registers.   |
// | Optional MIN_HIGH/MAX_HIGH tracking: define SMC_PWM_METER_MINMAX_EN.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module smc_pwm_meter #(
  parameter int         CNT_W     = 16,
  parameter logic [6:0] BASE_ADDR = 7'h40
) (
  input  wire logic      QCLK,
  input  wire logic      QRESET,
  smc_pwm_meter_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_ones = '1;
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [6:0]       ctl_q, ctl_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [15:0]      count_q, count_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             irq_q, irq_d;
`ifdef SMC_PWM_METER_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             w_mm_wr;
`endif

  logic [6:0]  w_off;
  logic        w_in_win, w_wr, w_rd, w_ctl_wr, w_stat_wr;
  logic        w_sel, w_rise, w_done, w_ovf_set, w_busy;
  logic [15:0] w_mnp_ext, w_mnm_ext;
  logic        w_unused_data;

  assign w_off     = bus.QADDR - BASE_ADDR;
  assign w_in_win  = (bus.QADDR >= BASE_ADDR) && (w_off <= 7'd6);
  assign w_wr      = bus.QSEL & bus.QWRITE & w_in_win;
  assign w_rd      = bus.QSEL & ~bus.QWRITE & w_in_win;
  assign w_ctl_wr  = w_wr && (w_off == 7'd0);
  assign w_stat_wr = w_wr && (w_off == 7'd1);
  assign w_busy    = (state_q != ST_IDLE);
  assign w_unused_data = ^bus.QDATAIN[15:7];

  // Zero-extended to 16 so CHSEL 12..15 lands on a constant 0.
  assign w_mnp_ext = {4'b0000, bus.MNP};
  assign w_mnm_ext = {4'b0000, bus.MNM};
  assign w_sel     = ctl_q[5] ? w_mnm_ext[ctl_q[4:1]] : w_mnp_ext[ctl_q[4:1]];
  assign w_rise    = w_sel & ~sel_q;

  always_comb begin
    state_d   = state_q;
    ctl_d     = ctl_q;
    sel_d     = w_sel;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    count_d   = count_q;
    w_done    = 1'b0;
    w_ovf_set = 1'b0;
    if (w_ctl_wr) begin
      // A CTL write overrides any edge or overflow seen on the same cycle.
      ctl_d     = bus.QDATAIN[6:0];
      per_cnt_d = '0;
      hi_cnt_d  = '0;
      if (bus.QDATAIN[0]) begin
        state_d = ST_ARM;
        sel_d   = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_ARM: begin
          if (w_rise) begin
            state_d   = ST_MEAS;
            per_cnt_d = c_cnt_one;
            hi_cnt_d  = c_cnt_one;
          end
        end
        ST_MEAS: begin
          if (w_rise) begin
            period_d  = per_cnt_q;
            high_d    = hi_cnt_q;
            count_d   = count_q + 16'd1;
            per_cnt_d = c_cnt_one;
            hi_cnt_d  = c_cnt_one;
            w_done    = 1'b1;
          end else if (per_cnt_q == c_cnt_ones) begin
            w_ovf_set = 1'b1;
            state_d   = ST_ARM;
            sel_d     = 1'b1;
          end else begin
            per_cnt_d = per_cnt_q + c_cnt_one;
            hi_cnt_d  = hi_cnt_q + CNT_W'(w_sel);
          end
        end
        default: ;
      endcase
    end
  end

  // Set beats write-1-to-clear; IRQ follows the next-state flags.
  always_comb begin
    valid_d = (valid_q & ~(w_stat_wr & bus.QDATAIN[0])) | w_done;
    ovf_d   = (ovf_q & ~(w_stat_wr & bus.QDATAIN[1])) | w_ovf_set;
    irq_d   = ctl_d[6] & (valid_d | ovf_d);
  end

`ifdef SMC_PWM_METER_MINMAX_EN
  assign w_mm_wr = w_wr && (w_off == 7'd5);

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (w_done) begin
      if (hi_cnt_q < min_q) min_d = hi_cnt_q;
      if (hi_cnt_q > max_q) max_d = hi_cnt_q;
    end
    if (w_mm_wr) begin
      min_d = c_cnt_ones;
      max_d = '0;
    end
  end
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (w_rd) begin
      case (w_off)
        7'd0:    rdata_d = {9'd0, ctl_q};
        7'd1:    rdata_d = {13'd0, w_busy, ovf_q, valid_q};
        7'd2:    rdata_d = 16'(period_q);
        7'd3:    rdata_d = 16'(high_q);
        7'd4:    rdata_d = count_q;
`ifdef SMC_PWM_METER_MINMAX_EN
        7'd5:    rdata_d = 16'(min_q);
        7'd6:    rdata_d = 16'(max_q);
`endif
        default: rdata_d = 16'd0;
      endcase
    end
  end

  always_ff @(posedge QCLK or posedge QRESET) begin
    if (QRESET) begin
      state_q   <= ST_IDLE;
      ctl_q     <= '0;
      sel_q     <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      count_q   <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
`ifdef SMC_PWM_METER_MINMAX_EN
      min_q     <= c_cnt_ones;
      max_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ctl_q     <= ctl_d;
      sel_q     <= sel_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      count_q   <= count_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
`ifdef SMC_PWM_METER_MINMAX_EN
      min_q     <= min_d;
      max_q     <= max_d;
`endif
    end
  end

  assign bus.QDATAOUT = rdata_q;
  assign bus.IRQ      = irq_q;
endmodule
`default_nettype wire
